fsm_control_unit: RTL

- Multi-cycle FSM control unit that sequences the processor and acts as initiator of the ALU operation interface.
- Fetches 16-bit instructions and decodes them into ALU operation and function codes.
- Captures the ALU zero, negative and carry flags into a flag register and uses them to resolve branches.
- Drives the register-file and data-memory strobes; sits between instruction memory, data memory, register file and ALU.

---
 rtl/fsm_control_unit.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/fsm_control_unit.sv
// Multi-cycle control sequencer: fetch, decode, ALU execute, data-memory access and write-back.
// Define CU_EXT_BRANCH_EN to implement BLT (opcode 7) and BCS (opcode 8); otherwise they decode as illegal.
module fsm_control_unit #(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  output logic [PC_W-1:0] pc,
  output logic [15:0]     ir,
  output logic [1:0]      alu_op,
  output logic [2:0]      alu_funct,
  output logic            alu_src_imm,
  input  logic            alu_zero,
  input  logic            alu_negative,
  input  logic            alu_carry,
  output logic [2:0]      flags,
  output logic            mem_rd,
  output logic            mem_wr,
  input  logic            mem_ack,
  output logic            reg_we,
  output logic            wb_sel_mem,
  output logic            halted,
  output logic            illegal,
  output logic [2:0]      state
);

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_RTYPE = 4'h1;
  localparam logic [3:0] OP_ADDI  = 4'h2;
  localparam logic [3:0] OP_LOAD  = 4'h3;
  localparam logic [3:0] OP_STORE = 4'h4;
  localparam logic [3:0] OP_BEQ   = 4'h5;
  localparam logic [3:0] OP_BNE   = 4'h6;
`ifdef CU_EXT_BRANCH_EN
  localparam logic [3:0] OP_BLT   = 4'h7;
  localparam logic [3:0] OP_BCS   = 4'h8;
`endif
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;
  localparam logic [1:0] ALU_PASS = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [PC_W-1:0]   pc_q;
  logic [15:0]       ir_q;
  logic [2:0]        flags_q;
  logic              illegal_q;
  logic [3:0]        opcode;
  logic              op_legal;
  logic              br_taken;
  logic [PC_W-1:0]   br_off;

  assign opcode    = ir_q[15:12];
  assign br_off    = PC_W'($signed(ir_q[7:0]));
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign flags     = flags_q;
  assign illegal   = illegal_q;
  assign state     = state_q;
  assign alu_funct = ir_q[11:9];

  // Opcode legality and branch resolution against the live ALU flags
  always_comb begin
    op_legal = 1'b1;
    br_taken = 1'b0;
    case (opcode)
      OP_NOP, OP_RTYPE, OP_ADDI, OP_LOAD, OP_STORE, OP_HALT: op_legal = 1'b1;
      OP_BEQ: br_taken = alu_zero;
      OP_BNE: br_taken = !alu_zero;
`ifdef CU_EXT_BRANCH_EN
      OP_BLT: br_taken = alu_negative;
      OP_BCS: br_taken = alu_carry;
`endif
      default: op_legal = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    state_d     = state_q;
    imem_req    = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    reg_we      = 1'b0;
    wb_sel_mem  = 1'b0;
    halted      = 1'b0;
    alu_op      = ALU_PASS;
    alu_src_imm = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (opcode == OP_HALT)                   state_d = S_HALT;
        else if (!op_legal || opcode == OP_NOP)  state_d = S_FETCH;
        else                                     state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        case (opcode)
          OP_RTYPE: begin
            alu_op  = ALU_FUNC;
            state_d = S_WRITEBACK;
          end
          OP_ADDI: begin
            alu_op      = ALU_ADD;
            alu_src_imm = 1'b1;
            state_d     = S_WRITEBACK;
          end
          OP_LOAD, OP_STORE: begin
            alu_op      = ALU_ADD;
            alu_src_imm = 1'b1;
            state_d     = S_MEMORY;
          end
          default: begin
            alu_op  = ALU_SUB;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMORY: begin
        mem_rd = (opcode == OP_LOAD);
        mem_wr = (opcode == OP_STORE);
        if (mem_ack) state_d = (opcode == OP_LOAD) ? S_WRITEBACK : S_FETCH;
      end
      S_WRITEBACK: begin
        reg_we     = 1'b1;
        wb_sel_mem = (opcode == OP_LOAD);
        state_d    = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

  // Architectural registers: PC, instruction, flags and sticky illegal
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      flags_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (state_q == S_FETCH && imem_ack) begin
        ir_q <= imem_data;
        pc_q <= pc_q + PC_W'(1);
      end
      if (state_q == S_DECODE && !op_legal) illegal_q <= 1'b1;
      if (state_q == S_EXECUTE) begin
        flags_q <= {alu_carry, alu_negative, alu_zero};
        if (br_taken) pc_q <= pc_q + br_off;
      end
    end
  end

endmodule
